// File: rtl/eth_tx_arbiter_if.sv
// Grant/handshake bundle between the TX arbiter and its clients, preamble
// generator and tx mux.
//   req            client frame requests, level, held until granted
//   tx_frame_done  end-of-FCS pulse from the tx mux
//   gnt / gnt_id   one-hot grant and its index
//   tx_start       one-cycle kick to the preamble/SFD generator
//   busy           a frame or its hold-off gap is in progress
//   timeout_err    one-cycle pulse when the watchdog releases the path
//   frame_cnt      completed-frame counter
// master: the arbiter side.  slave: the clients / tx path side.
interface eth_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 3
) ();
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic               tx_frame_done;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               tx_start;
    logic               busy;
    logic               timeout_err;
    logic [15:0]        frame_cnt;

    modport master (
        input  req, tx_frame_done,
        output gnt, gnt_id, tx_start, busy, timeout_err, frame_cnt
    );

    modport slave (
        output req, tx_frame_done,
        input  gnt, gnt_id, tx_start, busy, timeout_err, frame_cnt
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Round-robin scheduler for the shared Ethernet TX frame path. Grants one of
// the ARP / ICMP / UDP frame builders per frame, pulses tx_start, holds the
// grant until the tx mux reports end of frame (or the watchdog expires) and
// then inserts HOLDOFF_CYCLES+1 idle cycles before the next arbitration.
//   aclk     clock
//   aresetn  synchronous active-low reset; aborts any frame in flight
//   bus      eth_tx_arbiter_if.master (req/tx_frame_done in, grant side out)
module eth_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned HOLDOFF_CYCLES = 0
) (
    input  logic               aclk,
    input  logic               aresetn,
    eth_tx_arbiter_if.master   bus
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HO_W = $clog2(HOLDOFF_CYCLES + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_ACTIVE,
        ST_HOLDOFF
    } state_t;

    state_t          state;
    logic [ID_W-1:0] last;
    logic [WD_W-1:0] wd;
    logic [HO_W-1:0] ho;

    logic [ID_W-1:0] pick_c;
    logic [ID_W-1:0] idx_c;
    logic            found_c;

    // Round-robin pick: first set request strictly after the last winner, wrapping.
    always_comb begin
        pick_c  = last;
        idx_c   = last;
        found_c = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx_c = ID_W'((32'(last) + i) % NUM_REQ);
            if (!found_c && bus.req[idx_c]) begin
                pick_c  = idx_c;
                found_c = 1'b1;
            end
        end
    end

    // Frame scheduling FSM with registered outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state           <= ST_IDLE;
            last            <= ID_W'(NUM_REQ - 1);
            wd              <= '0;
            ho              <= '0;
            bus.gnt         <= '0;
            bus.gnt_id      <= '0;
            bus.tx_start    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.frame_cnt   <= '0;
        end else begin
            bus.tx_start    <= 1'b0;
            bus.timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        bus.gnt      <= NUM_REQ'(1) << pick_c;
                        bus.gnt_id   <= pick_c;
                        last         <= pick_c;
                        bus.tx_start <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= ST_START;
                    end
                end
                ST_START: begin
                    wd    <= '0;
                    state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    // Completion takes priority over a coincident watchdog expiry.
                    if (bus.tx_frame_done) begin
                        bus.gnt       <= '0;
                        bus.frame_cnt <= bus.frame_cnt + 16'd1;
                        ho            <= '0;
                        state         <= ST_HOLDOFF;
                    end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.gnt         <= '0;
                        bus.timeout_err <= 1'b1;
                        ho              <= '0;
                        state           <= ST_HOLDOFF;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (ho == HO_W'(HOLDOFF_CYCLES)) begin
                        bus.busy <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        ho <= ho + HO_W'(1);
                    end
                end
                default: begin
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
